// File: rtl/snake_pkg.sv
// Shared snake-game constants: game-state encoding plus default grid and tick timing.
package snake_pkg;

  localparam int unsigned GRID_X         = 10;
  localparam int unsigned GRID_Y         = 10;
  localparam int unsigned TICK_BASE_CLK  = 12000000;
  localparam int unsigned TICK_MIN_CLK   = 3000000;
  localparam int unsigned TICK_DEC_CLK   = 1000000;
  localparam int unsigned APPLES_PER_LVL = 5;
  localparam int unsigned LEVEL_MAX      = 15;
  localparam int unsigned SCORE_BITS     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_e;

endpackage

// File: rtl/var_tick_timer.sv
// Variable-modulus tick counter; a new period is adopted only at a wrap or while cleared.
module var_tick_timer #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PER_W      = 24,
  parameter int unsigned RST_PERIOD = 12000000
) (
  input  logic             clk,
  input  logic             key0_rst,
  input  logic [PER_W-1:0] period,
  input  logic             enable,
  input  logic             clear,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] cur_q, cur_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] last_c;

  assign last_c = CNT_W'(cur_q - PER_W'(1));

  always_comb begin
    cnt_d  = cnt_q;
    cur_d  = cur_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      cur_d = period;
    end else if (enable) begin
      if (cnt_q == last_c) begin
        cnt_d  = '0;
        cur_d  = period;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      cnt_q  <= '0;
      cur_q  <= PER_W'(RST_PERIOD);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: run/pause/over/win FSM, score/level/high-score tracking
// and a level-dependent step tick.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned SIZE_X           = GRID_X,
  parameter int unsigned SIZE_Y           = GRID_Y,
  parameter int unsigned BASE_TICK_CLK    = TICK_BASE_CLK,
  parameter int unsigned MIN_TICK_CLK     = TICK_MIN_CLK,
  parameter int unsigned TICK_DEC         = TICK_DEC_CLK,
  parameter int unsigned APPLES_PER_LEVEL = APPLES_PER_LVL,
  parameter int unsigned MAX_LEVEL        = LEVEL_MAX,
  parameter int unsigned SCORE_W          = SCORE_BITS
) (
  input  logic                               clk,
  input  logic                               key0_rst,
  input  logic                               start_key,
  input  logic                               pause_key,
  input  logic                               apple_eaten,
  input  logic                               dead,
  input  logic [15:0]                        snake_len,
  output logic                               step,
  output logic                               game_start,
  output logic [2:0]                         game_state,
  output logic [SCORE_W-1:0]                 score,
  output logic [SCORE_W-1:0]                 high_score,
  output logic [$clog2(MAX_LEVEL+1)-1:0]     level
);

  localparam int unsigned LVL_W = $clog2(MAX_LEVEL + 1);
  localparam int unsigned APL_W = $clog2(APPLES_PER_LEVEL + 1);
  localparam int unsigned CNT_W = $clog2(BASE_TICK_CLK);
  localparam int unsigned PER_W = $clog2(BASE_TICK_CLK + 1);
  localparam int unsigned CELLS = SIZE_X * SIZE_Y;

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [APL_W-1:0]   apple_q, apple_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic               gstart_q, gstart_d;
  logic               tmr_en, tmr_clear, tmr_tick;

  // Saturating period = max(MIN, BASE - lvl*DEC) without underflow.
  function automatic logic [PER_W-1:0] period_for(input logic [LVL_W-1:0] lvl);
    int unsigned dec;
    dec = 32'(lvl) * TICK_DEC;
    if (dec >= BASE_TICK_CLK - MIN_TICK_CLK) return PER_W'(MIN_TICK_CLK);
    else return PER_W'(BASE_TICK_CLK - dec);
  endfunction

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    level_d  = level_q;
    apple_d  = apple_q;
    gstart_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start_key) begin
          state_d  = ST_RUN;
          gstart_d = 1'b1;
          score_d  = '0;
          level_d  = '0;
          apple_d  = '0;
        end
      end
      ST_RUN: begin
        if (apple_eaten) begin
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          if (apple_q == APL_W'(APPLES_PER_LEVEL - 1)) begin
            apple_d = '0;
            if (level_q != LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
          end else begin
            apple_d = apple_q + APL_W'(1);
          end
        end
        if (dead)                           state_d = ST_OVER;
        else if (32'(snake_len) >= CELLS)   state_d = ST_WIN;
        else if (pause_key)                 state_d = ST_PAUSE;
        if ((state_d == ST_OVER || state_d == ST_WIN) && score_d > high_q) high_d = score_d;
      end
      ST_PAUSE: begin
        if (pause_key) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    // Parked at BASE outside a game so a restart always begins at the level-0 rate.
    if (gstart_d || !(state_d == ST_RUN || state_d == ST_PAUSE))
      period_d = PER_W'(BASE_TICK_CLK);
    else
      period_d = period_for(level_q);
  end

  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      high_q   <= '0;
      level_q  <= '0;
      apple_q  <= '0;
      period_q <= PER_W'(BASE_TICK_CLK);
      gstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      high_q   <= high_d;
      level_q  <= level_d;
      apple_q  <= apple_d;
      period_q <= period_d;
      gstart_q <= gstart_d;
    end
  end

  // Count only RUN cycles that stay in play; a game-ending cycle never emits a step.
  assign tmr_clear = (state_q == ST_IDLE) || (state_q == ST_OVER) || (state_q == ST_WIN);
  assign tmr_en    = (state_q == ST_RUN) && (state_d == ST_RUN || state_d == ST_PAUSE);

  var_tick_timer #(
    .CNT_W      (CNT_W),
    .PER_W      (PER_W),
    .RST_PERIOD (BASE_TICK_CLK)
  ) u_tick (
    .clk      (clk),
    .key0_rst (key0_rst),
    .period   (period_q),
    .enable   (tmr_en),
    .clear    (tmr_clear),
    .tick     (tmr_tick)
  );

  assign step       = tmr_tick;
  assign game_start = gstart_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign level      = level_q;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game-level controller for the snake game: run/pause/over/win state machine, score, level and high-score tracking, and a speed-adaptive step tick.
- Successor to the fixed-modulus tick plus implicit dead/grow loop: tick period shrinks as the level rises, with explicit pause and win modes.
- Sits between keyboard decode (start/pause pulses) and snake_calculate/field_calculate.
- Drives their step and start inputs and consumes apple/dead events.

Parameters:
SIZE_X, 10, grid width in cells
SIZE_Y, 10, grid height in cells
BASE_TICK_CLK, 12000000, step period in clk cycles at level 0
MIN_TICK_CLK, 3000000, floor on step period
TICK_DEC, 1000000, period reduction per level
APPLES_PER_LEVEL, 5, apples eaten per level increment
MAX_LEVEL, 15, level saturation value
SCORE_W, 16, score/high-score width

Ports:
clk  in  1  system clock
key0_rst  in  1  asynchronous active-low reset
start_key  in  1  1-cycle pulse, start/restart request
pause_key  in  1  1-cycle pulse, pause toggle
apple_eaten  in  1  1-cycle pulse, snake grew
dead  in  1  1-cycle pulse, collision detected
snake_len  in  16  current snake length in cells
step  out  1  1-cycle move pulse to snake_calculate
game_start  out  1  1-cycle pulse, reinitialise snake/field
game_state  out  3  one of IDLE/RUN/PAUSE/OVER/WIN
score  out  SCORE_W  apples eaten this game
high_score  out  SCORE_W  best score since reset
level  out  $clog2(MAX_LEVEL+1)  current speed level

Behaviour:
Reset (key0_rst low, async):
- Clears everything: state=IDLE; step, game_start, score, high_score, level, apple counter and tick counter all 0.
- Period register = BASE_TICK_CLK.

State machine, evaluated each cycle:
- IDLE/OVER/WIN + start_key -> RUN.
  - Same cycle registers game_start=1 for exactly one cycle.
  - Clears score, level, apple counter, tick counter; period reloads BASE_TICK_CLK.
- RUN + dead -> OVER.
- RUN + snake_len >= SIZE_X*SIZE_Y -> WIN. Evaluated after apple update.
- RUN + pause_key -> PAUSE. PAUSE + pause_key -> RUN.
- Ignored inputs:
  - start_key in RUN/PAUSE.
  - pause_key in IDLE/OVER/WIN.
  - dead/apple_eaten outside RUN.
- Priority in RUN for the same cycle: dead > win > pause. apple_eaten is still scored when dead is taken.

Tick generator (RUN only):
- Counter increments each cycle. When it equals period-1, step=1 for one cycle and the counter returns to 0.
- First step occurs period cycles after the RUN-entry cycle.
- Counter holds in PAUSE, resuming without loss of phase. It is cleared in IDLE/OVER/WIN.
- Period = max(MIN_TICK_CLK, BASE_TICK_CLK - level*TICK_DEC).
  - Computed with saturating subtract, no underflow.
  - Registered one cycle after the level changes; the new period applies from the next counter wrap.
  - Counter width is $clog2(BASE_TICK_CLK).

Scoring:
- apple_eaten in RUN: score+1, saturating at all-ones.
- Apple counter +1; on reaching APPLES_PER_LEVEL it resets to 0 and level+1, saturating at MAX_LEVEL.
- Entering OVER or WIN: high_score <= max(high_score, score including any same-cycle apple). high_score survives restart.

Outputs are registered. game_state reflects the new state the cycle after the triggering input.

Decomposition:
- Package snake_pkg holds:
  - game_state encodings: IDLE=0, RUN=1, PAUSE=2, OVER=3, WIN=4.
  - Default grid sizes and tick constants, replacing the GRID_* / TICK_TIME_CLK defines.
- Sub-module var_tick_timer: variable-modulus tick counter.
  - Inputs: period, enable, clear.
  - Output: tick.
  - Same clk/key0_rst.

Test Plan:
(Bench params: BASE_TICK_CLK=20, MIN_TICK_CLK=8, TICK_DEC=4, APPLES_PER_LEVEL=2, MAX_LEVEL=5, SIZE_X=SIZE_Y=2.)
- Reset then start_key at cycle 0 -> game_start high exactly at cycle 1, state=RUN; step pulses at cycles 21, 41, 61.
- 6 apple_eaten pulses in RUN -> score=6; level 1, 2, 3 after apples 2, 4, 6; step spacing becomes 16, 12, then 8 (floor). Further apples leave the period at 8 and level saturates at 5.
- pause_key 5 cycles after a step, hold 100 cycles, pause_key again -> no step during PAUSE; next step exactly 15 cycles after resume.
- apple_eaten and dead in the same cycle with score=3, high_score=0 -> state=OVER, score=4, high_score=4. start_key -> score=0, high_score stays 4.
- snake_len driven to 4 in RUN -> state=WIN, step stops. dead afterwards -> no change. start_key -> RUN with game_start pulse.
- key0_rst low mid-RUN with a step pending -> all outputs 0 immediately and asynchronously, state=IDLE; no step after release until start_key.
